reg_scoreboard: RTL and testbench

Register-hazard scoreboard for the 5-stage 16-bit pipeline. It sits directly upstream of the ID-stage controller. It tracks every in-flight register write as it moves from EX through MEM to WB. Each cycle it drives `register_invalid[7:0]`, the per-register 3-bit code the controller uses to choose between regfile read, EX/MEM forward, MEM/WB forward, or stall. All outputs come from registered state only, so there is no combinational path from any input to any output. This breaks the loop regwrite_cur → flush_idex → data_hazard → register_invalid.

---
 rtl/reg_scoreboard_if.sv | 30 +++
 rtl/reg_scoreboard.sv | 81 ++++++++
 tb/tb_reg_scoreboard.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// Controller-to-scoreboard bundle: ID-stage write info, pipeline enables/flushes,
// and the per-register hazard codes returned to the controller.
interface reg_scoreboard_if #(
  parameter int NREG = 8,
  parameter int AW   = 3
);
  logic          regwrite_cur;
  logic [AW-1:0] wr_adr_id;
  logic          from_main_mem;
  logic          en_idex;
  logic          flush_idex;
  logic          en_exmem;
  logic          flush_exmem;
  logic          en_memwb;
  logic          flush_memwb;
  logic [2:0]    register_invalid [NREG-1:0];
  logic          pipe_empty;

  modport master (
    output regwrite_cur, wr_adr_id, from_main_mem,
    output en_idex, flush_idex, en_exmem, flush_exmem, en_memwb, flush_memwb,
    input  register_invalid, pipe_empty
  );

  modport slave (
    input  regwrite_cur, wr_adr_id, from_main_mem,
    input  en_idex, flush_idex, en_exmem, flush_exmem, en_memwb, flush_memwb,
    output register_invalid, pipe_empty
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: tracks in-flight writes through EX/MEM/WB and
// reports a per-register stall/forward code derived purely from registered state.
module reg_scoreboard #(
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input logic             clk,
  input logic             rst_n,
  reg_scoreboard_if.slave i_bus
);

  logic          r_e_valid;
  logic [AW-1:0] r_e_adr;
  logic          r_e_ld;
  logic          r_m_valid;
  logic [AW-1:0] r_m_adr;
  logic          r_m_ld;
  logic          r_w_valid;
  logic [AW-1:0] r_w_adr;
  logic          r_w_ld;
  logic [2:0]    w_code [NREG-1:0];

  // Each slot applies flush before enable; a flush drops only the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_valid <= 1'b0;
      r_e_adr   <= '0;
      r_e_ld    <= 1'b0;
    end else if (i_bus.flush_idex) begin
      r_e_valid <= 1'b0;
    end else if (i_bus.en_idex) begin
      r_e_valid <= i_bus.regwrite_cur;
      r_e_adr   <= i_bus.wr_adr_id;
      r_e_ld    <= i_bus.from_main_mem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_adr   <= '0;
      r_m_ld    <= 1'b0;
    end else if (i_bus.flush_exmem) begin
      r_m_valid <= 1'b0;
    end else if (i_bus.en_exmem) begin
      r_m_valid <= r_e_valid;
      r_m_adr   <= r_e_adr;
      r_m_ld    <= r_e_ld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_valid <= 1'b0;
      r_w_adr   <= '0;
      r_w_ld    <= 1'b0;
    end else if (i_bus.flush_memwb) begin
      r_w_valid <= 1'b0;
    end else if (i_bus.en_memwb) begin
      r_w_valid <= r_m_valid;
      r_w_adr   <= r_m_adr;
      r_w_ld    <= r_m_ld;
    end
  end

  // Youngest producer wins; W never hazards because the regfile is write-first.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_code[i] = 3'd0;
      if (r_e_valid && (r_e_adr == AW'(i))) begin
        w_code[i] = r_e_ld ? 3'd1 : 3'd2;
      end else if (r_m_valid && (r_m_adr == AW'(i))) begin
        w_code[i] = 3'd3;
      end
    end
  end

  assign i_bus.register_invalid = w_code;
  assign i_bus.pipe_empty       = !(r_e_valid || r_m_valid || r_w_valid);

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard: each step drives one clock edge,
// then checks every register code and pipe_empty on the following falling edge.
module tb_reg_scoreboard;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  reg_scoreboard_if #(.NREG(8), .AW(3)) sbBus ();

  reg_scoreboard #(.NREG(8), .AW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_bus (sbBus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] code(input int idx, input logic [2:0] c);
    logic [23:0] v;
    v = '0;
    v[3*idx +: 3] = c;
    return v;
  endfunction

  task automatic setIdle();
    sbBus.regwrite_cur  = 1'b0;
    sbBus.wr_adr_id     = 3'd0;
    sbBus.from_main_mem = 1'b0;
    sbBus.en_idex       = 1'b1;
    sbBus.flush_idex    = 1'b0;
    sbBus.en_exmem      = 1'b1;
    sbBus.flush_exmem   = 1'b0;
    sbBus.en_memwb      = 1'b1;
    sbBus.flush_memwb   = 1'b0;
  endtask

  // Drives one set of inputs across a single rising edge, then returns to idle
  // and waits for the falling edge where outputs are sampled.
  task automatic applyStimulus(input logic rw, input logic [2:0] adr, input logic ld,
                               input logic enIdex, input logic flIdex,
                               input logic enExmem, input logic flExmem,
                               input logic enMemwb, input logic flMemwb);
    sbBus.regwrite_cur  = rw;
    sbBus.wr_adr_id     = adr;
    sbBus.from_main_mem = ld;
    sbBus.en_idex       = enIdex;
    sbBus.flush_idex    = flIdex;
    sbBus.en_exmem      = enExmem;
    sbBus.flush_exmem   = flExmem;
    sbBus.en_memwb      = enMemwb;
    sbBus.flush_memwb   = flMemwb;
    @(posedge clk);
    #1;
    setIdle();
    @(negedge clk);
  endtask

  task automatic idleStep();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic writeStep(input logic [2:0] adr, input logic ld);
    applyStimulus(1'b1, adr, ld, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [23:0] expCodes, input logic expEmpty);
    logic [23:0] obsCodes;
    for (int i = 0; i < 8; i++) obsCodes[3*i +: 3] = sbBus.register_invalid[i];
    checks++;
    assert (obsCodes === expCodes) else begin
      failures++;
      $error("[TB] FAIL %s codes: observed=%h expected=%h", tag, obsCodes, expCodes);
    end
    checks++;
    assert (sbBus.pipe_empty === expEmpty) else begin
      failures++;
      $error("[TB] FAIL %s pipe_empty: observed=%b expected=%b", tag, sbBus.pipe_empty, expEmpty);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    setIdle();
    #1;
    checkOutput("reset", 24'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] ALU write to r3");
    writeStep(3'd3, 1'b0);
    checkOutput("alu_c1", code(3, 3'd2), 1'b0);
    idleStep();
    checkOutput("alu_c2", code(3, 3'd3), 1'b0);
    idleStep();
    checkOutput("alu_c3", 24'h0, 1'b0);
    idleStep();
    checkOutput("alu_c4", 24'h0, 1'b1);

    $display("[TB] load-use stall on r5");
    writeStep(3'd5, 1'b1);
    checkOutput("ld_c1", code(5, 3'd1), 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("ld_c2", code(5, 3'd3), 1'b0);
    idleStep();
    checkOutput("ld_c3", 24'h0, 1'b0);
    idleStep();
    checkOutput("ld_c4", 24'h0, 1'b1);

    $display("[TB] back-to-back writes to r2");
    writeStep(3'd2, 1'b1);
    checkOutput("b2b_c1", code(2, 3'd1), 1'b0);
    writeStep(3'd2, 1'b0);
    checkOutput("b2b_c2", code(2, 3'd2), 1'b0);
    idleStep();
    checkOutput("b2b_c3", code(2, 3'd3), 1'b0);
    idleStep();
    checkOutput("b2b_c4", 24'h0, 1'b0);
    idleStep();
    checkOutput("b2b_c5", 24'h0, 1'b1);

    $display("[TB] jump flush with r1 and r6 in flight");
    writeStep(3'd1, 1'b0);
    checkOutput("jmp_c1", code(1, 3'd2), 1'b0);
    writeStep(3'd6, 1'b0);
    checkOutput("jmp_c2", code(1, 3'd3) | code(6, 3'd2), 1'b0);
    applyStimulus(1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("jmp_c3", 24'h0, 1'b1);

    $display("[TB] hold r4 in E for three cycles");
    writeStep(3'd4, 1'b0);
    checkOutput("hold_c1", code(4, 3'd2), 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("hold_stall%0d", k), code(4, 3'd2), 1'b0);
    end
    idleStep();
    checkOutput("hold_m", code(4, 3'd3), 1'b0);
    idleStep();
    checkOutput("hold_w", 24'h0, 1'b0);
    idleStep();
    checkOutput("hold_done", 24'h0, 1'b1);

    $display("[TB] asynchronous reset with r7 in flight");
    writeStep(3'd7, 1'b0);
    checkOutput("rst_pre", code(7, 3'd2), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async", 24'h0, 1'b1);
    @(negedge clk);
    checkOutput("rst_hold", 24'h0, 1'b1);
    rst_n = 1'b1;
    writeStep(3'd3, 1'b0);
    checkOutput("post_c1", code(3, 3'd2), 1'b0);
    idleStep();
    checkOutput("post_c2", code(3, 3'd3), 1'b0);
    idleStep();
    checkOutput("post_c3", 24'h0, 1'b0);
    idleStep();
    checkOutput("post_c4", 24'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
